jk_excite_drv: RTL and testbench

JK_EXCITE_DRV -- requirements
Module: jk_excite_drv

---
 rtl/jk_excite_drv.sv | 157 +++++++++++++++
 tb/tb_jk_excite_drv.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excite_drv.sv
// JK register excitation driver: queues target words, drives one J/K pulse per word, then a check cycle.
// Optional readback checking is enabled by defining JK_EXCITE_CHECK_EN.
`timescale 1ns/1ps

module jk_excite_drv #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int MODE  = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             err,
    output logic [7:0]       err_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // Handshake: a word transfers on a rising edge where in_valid and in_ready are both 1;
    // in_ready depends only on FIFO occupancy and clr, never on in_valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] j_nxt;
    logic [WIDTH-1:0] k_nxt;

    assign in_ready = clr && (count < DEPTH_C);
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && (count != '0);
    assign head     = mem[rd_ptr];

    // FIFO storage needs no reset: the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Excitation from current register value (q_fb) towards the target (head).
    always_comb begin
        j_nxt = '0;
        k_nxt = '0;
        if (MODE == 1) begin
            j_nxt = q_fb ^ head;
            k_nxt = q_fb ^ head;
        end else begin
            j_nxt = ~q_fb & head;
            k_nxt = q_fb & ~head;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (count != '0) ? DRIVE : IDLE;
            DRIVE:   state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done = 1'b0;
        if (state == CHECK) begin
            done = 1'b1;
        end
    end

    // j/k are loaded only on the IDLE->DRIVE pop, so they are zero outside DRIVE.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            j <= '0;
            k <= '0;
        end else if (pop) begin
            j <= j_nxt;
            k <= k_nxt;
        end else if (state == DRIVE) begin
            j <= '0;
            k <= '0;
        end
    end

`ifdef JK_EXCITE_CHECK_EN
    logic [WIDTH-1:0] tgt;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            tgt <= '0;
        end else if (pop) begin
            tgt <= head;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else if ((state == CHECK) && (q_fb != tgt)) begin
            err <= 1'b1;
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`else
    assign err     = 1'b0;
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_jk_excite_drv.sv
// Directed bench for jk_excite_drv: MODE 0 and MODE 1 instances driving a behavioural JK register.
`timescale 1ns/1ps

module tb_jk_excite_drv;

    localparam int W = 4;
`ifdef JK_EXCITE_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clr;
    logic         in_valid, in_valid1;
    logic [W-1:0] in_data, in_data1;
    logic [W-1:0] q_fb, q_fb1;
    logic         in_ready, in_ready1;
    logic [W-1:0] j, k, j1, k1;
    logic         done, done1, err, err1;
    logic [7:0]   err_cnt, err_cnt1;

    logic [W-1:0] q_ext, q_ext1;
    logic         preset;
    logic [W-1:0] preset_val;
    logic         fb_hold;
    logic [W-1:0] fb_val;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jk_excite_drv #(.WIDTH(W), .DEPTH(4), .MODE(0)) u_dut0 (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .q_fb(q_fb), .j(j), .k(k), .done(done), .err(err), .err_cnt(err_cnt)
    );

    jk_excite_drv #(.WIDTH(W), .DEPTH(4), .MODE(1)) u_dut1 (
        .clk(clk), .clr(clr), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .q_fb(q_fb1), .j(j1), .k(k1), .done(done1), .err(err1), .err_cnt(err_cnt1)
    );

    // External JK register behaviour: Q+ = J&~Q | ~K&Q per bit.
    always @(posedge clk) begin
        if (preset) begin
            q_ext  <= preset_val;
            q_ext1 <= preset_val;
        end else begin
            q_ext  <= (j & ~q_ext) | (~k & q_ext);
            q_ext1 <= (j1 & ~q_ext1) | (~k1 & q_ext1);
        end
    end

    assign q_fb  = fb_hold ? fb_val : q_ext;
    assign q_fb1 = q_ext1;

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b0;
        in_valid1 = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic set_q(input logic [W-1:0] v);
        @(negedge clk);
        preset = 1'b1;
        preset_val = v;
        @(negedge clk);
        preset = 1'b0;
    endtask

    task automatic push0(input logic [W-1:0] v);
        @(negedge clk);
        in_valid = 1'b1;
        in_data = v;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic push1(input logic [W-1:0] v);
        @(negedge clk);
        in_valid1 = 1'b1;
        in_data1 = v;
        @(posedge clk);
        #1 in_valid1 = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b1;
        in_data = 4'hF;
        in_valid1 = 1'b1;
        in_data1 = 4'hF;
        #1;
        checks++;
        if (in_ready !== 1'b0 || in_ready1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready: got %b/%b expected 0/0", in_ready, in_ready1);
        end
        checks++;
        if (j !== 4'b0000 || k !== 4'b0000 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got j=%b k=%b done=%b expected 0000 0000 0", j, k, done);
        end
        checks++;
        if (err !== 1'b0 || err_cnt !== 8'd0 || err1 !== 1'b0 || err_cnt1 !== 8'd0) begin
            failures++;
            $display("FAIL reset_err: got err=%b cnt=%0d expected 0 0", err, err_cnt);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_valid1 = 1'b0;
        clr = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || in_ready1 !== 1'b1) begin
            failures++;
            $display("FAIL release_in_ready: got %b/%b expected 1/1", in_ready, in_ready1);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (j !== 4'b0000 || done !== 1'b0) begin
                failures++;
                $display("FAIL reset_no_word: got j=%b done=%b expected 0000 0", j, done);
            end
        end
    endtask

    task automatic test_set();
        set_q(4'b0000);
        push0(4'b1010);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (j !== 4'b1010 || k !== 4'b0000 || done !== 1'b0) begin
            failures++;
            $display("FAIL set_drive: got j=%b k=%b done=%b expected 1010 0000 0", j, k, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || j !== 4'b0000 || k !== 4'b0000 || err !== 1'b0) begin
            failures++;
            $display("FAIL set_check: got done=%b j=%b k=%b err=%b expected 1 0000 0000 0", done, j, k, err);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || q_fb !== 4'b1010) begin
            failures++;
            $display("FAIL set_after: got done=%b q=%b expected 0 1010", done, q_fb);
        end
    endtask

    task automatic test_clear();
        set_q(4'b1010);
        push0(4'b0110);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (j !== 4'b0100 || k !== 4'b1000) begin
            failures++;
            $display("FAIL clear_drive: got j=%b k=%b expected 0100 1000", j, k);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || q_fb !== 4'b0110 || j !== 4'b0000 || k !== 4'b0000) begin
            failures++;
            $display("FAIL clear_check: got done=%b q=%b j=%b k=%b expected 1 0110 0000 0000", done, q_fb, j, k);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || err_cnt !== 8'd0 || done !== 1'b0) begin
            failures++;
            $display("FAIL clear_err: got err=%b cnt=%0d done=%b expected 0 0 0", err, err_cnt, done);
        end
    endtask

    task automatic test_toggle();
        set_q(4'b1010);
        push1(4'b0101);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (j1 !== 4'b1111 || k1 !== 4'b1111) begin
            failures++;
            $display("FAIL toggle_drive: got j=%b k=%b expected 1111 1111", j1, k1);
        end
        @(negedge clk);
        checks++;
        if (done1 !== 1'b1 || j1 !== 4'b0000 || k1 !== 4'b0000) begin
            failures++;
            $display("FAIL toggle_check: got done=%b j=%b k=%b expected 1 0000 0000", done1, j1, k1);
        end
        @(negedge clk);
        checks++;
        if (q_fb1 !== 4'b0101 || done1 !== 1'b0 || err1 !== 1'b0 || err_cnt1 !== 8'd0) begin
            failures++;
            $display("FAIL toggle_after: got q=%b done=%b err=%b expected 0101 0 0", q_fb1, done1, err1);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [6];
        logic [W-1:0] exp_j [6];
        logic [W-1:0] exp_k [6];
        int  idx;
        int  dones;
        bit  acc;
        bit  exp_rdy;
        bit  exp_done;
        words = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1000, 4'b0000};
        exp_j = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
        exp_k = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b1000};
        do_reset();
        set_q(4'b0000);
        idx = 0;
        dones = 0;
        for (int e = 0; e < 21; e++) begin
            @(negedge clk);
            if (e > 0) begin
                exp_rdy  = !(e == 6 || e == 7);
                exp_done = (e % 3 == 0) && (e >= 3) && (e <= 18);
                checks++;
                if (in_ready !== exp_rdy) begin
                    failures++;
                    $display("FAIL b2b_ready e=%0d: got %b expected %b", e, in_ready, exp_rdy);
                end
                checks++;
                if (done !== exp_done) begin
                    failures++;
                    $display("FAIL b2b_done e=%0d: got %b expected %b", e, done, exp_done);
                end
                if (done === 1'b1) dones++;
                if ((e % 3 == 2) && (e <= 17)) begin
                    checks++;
                    if (j !== exp_j[(e-2)/3] || k !== exp_k[(e-2)/3]) begin
                        failures++;
                        $display("FAIL b2b_jk e=%0d: got j=%b k=%b expected %b %b", e, j, k,
                                 exp_j[(e-2)/3], exp_k[(e-2)/3]);
                    end
                end else begin
                    checks++;
                    if (j !== 4'b0000 || k !== 4'b0000) begin
                        failures++;
                        $display("FAIL b2b_jk_idle e=%0d: got j=%b k=%b expected 0000 0000", e, j, k);
                    end
                end
            end
            in_valid = (idx < 6);
            in_data  = (idx < 6) ? words[idx] : 4'b0000;
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        checks++;
        if (dones != 6 || idx != 6) begin
            failures++;
            $display("FAIL b2b_count: got dones=%0d pushes=%0d expected 6 6", dones, idx);
        end
        checks++;
        if (q_fb !== 4'b0000) begin
            failures++;
            $display("FAIL b2b_final_q: got %b expected 0000", q_fb);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        fb_hold = 1'b1;
        fb_val = 4'b0000;
        push0(4'b1111);
        push0(4'b1111);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL mis_first_check: got done=%b err=%b expected 1 0", done, err);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (err !== CHK_EN || err_cnt !== (CHK_EN ? 8'd1 : 8'd0)) begin
            failures++;
            $display("FAIL mis_first: got err=%b cnt=%0d expected %b %0d", err, err_cnt, CHK_EN, CHK_EN ? 1 : 0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (err !== CHK_EN || err_cnt !== (CHK_EN ? 8'd2 : 8'd0)) begin
            failures++;
            $display("FAIL mis_second: got err=%b cnt=%0d expected %b %0d", err, err_cnt, CHK_EN, CHK_EN ? 2 : 0);
        end
        fb_hold = 1'b0;
    endtask

    task automatic test_abort();
        do_reset();
        set_q(4'b0000);
        push0(4'b0011);
        push0(4'b0111);
        push0(4'b1100);
        push0(4'b1010);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (j !== 4'b0100 || k !== 4'b0000) begin
            failures++;
            $display("FAIL abort_drive: got j=%b k=%b expected 0100 0000", j, k);
        end
        #1 clr = 1'b0;
        #1;
        checks++;
        if (j !== 4'b0000 || k !== 4'b0000 || in_ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL abort_async: got j=%b k=%b rdy=%b done=%b expected 0000 0000 0 0", j, k, in_ready, done);
        end
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || j !== 4'b0000 || k !== 4'b0000 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL abort_after c=%0d: got done=%b j=%b k=%b rdy=%b expected 0 0000 0000 1",
                         c, done, j, k, in_ready);
            end
        end
    endtask

    initial begin
        clr = 1'b0;
        in_valid = 1'b0;
        in_valid1 = 1'b0;
        in_data = '0;
        in_data1 = '0;
        preset = 1'b0;
        preset_val = '0;
        fb_hold = 1'b0;
        fb_val = '0;
        test_reset();
        test_set();
        test_clear();
        test_toggle();
        test_back_to_back();
        test_mismatch();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
